sched_conv_32_8: RTL
====================

# sched_conv_32_8

Two-lane round-robin scheduler that shares one 32-to-8 serialization path between two 32-bit FIFOs in the PHY transmit path. It pops words from the FIFOs, holds up to two words (current and prefetched), and emits each word as four bytes, MSB first, one byte per `clk_4f` cycle. Each byte is tagged with its source lane and a first-byte marker. A downstream `pause` stalls emission without losing data.

## Interface
- `IDLE_BYTE`, default 8'hBC: value driven on `data_out` when no byte is valid. Used only with `SCHED_IDLE_COMMA_EN`.

- `clk_4f`  in  1  byte-rate clock; every register is clocked on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fifo0_empty`  in  1  lane 0 FIFO empty flag.
- `fifo0_data`  in  32  lane 0 read data; valid the cycle after `fifo0_pop`.
- `fifo0_pop`  out  1  lane 0 pop strobe, combinational.
- `fifo1_empty`  in  1  lane 1 FIFO empty flag.
- `fifo1_data`  in  32  lane 1 read data; valid the cycle after `fifo1_pop`.
- `fifo1_pop`  out  1  lane 1 pop strobe, combinational.
- `pause`  in  1  downstream stall request.
- `data_out`  out  8  serialized byte, registered.
- `valid_out`  out  1  `data_out` is valid, registered.
- `lane_out`  out  1  source lane of `data_out`, registered.
- `first_out`  out  1  high on byte 0 (bits [31:24]) of a word, registered.

## Operation
- Internal state:
  - `cur_word`/`cur_lane`/`cur_valid`: current word.
  - `beat[1:0]`: byte index within the current word.
  - `nxt_word`/`nxt_lane`/`nxt_valid`: prefetched word.
  - `pend`/`pend_lane`: a pop was issued last cycle.
  - `last_grant`: lane granted most recently.
- Pop rule: a pop is issued when `!pend && !nxt_valid` and the selected lane is non-empty. Pop is asserted in the same cycle (combinational).
  - At most one pop per cycle.
  - Never pop a lane whose empty flag is high.
  - `pause` does not block pops.
- Arbitration:
  - If both lanes are non-empty, grant `!last_grant`.
  - If only one lane is non-empty, grant that lane.
  - `last_grant` updates on every issued pop.
- Data return: in the cycle with `pend` = 1, the data of `pend_lane` is taken.
  - If `cur` is free this cycle, the data goes to `cur` (bypass) with `beat` = 0.
  - Otherwise the data goes to `nxt` and `nxt_valid` is set.
- `cur` is free this cycle when `cur_valid` = 0, or when a byte with `beat` = 3 is emitted this cycle.
- When `cur` is free and `nxt_valid` = 1, load `cur` from `nxt` and clear `nxt_valid`. This takes priority over bypass. A `pend` in the same cycle cannot coincide with `nxt_valid` = 1.
- Emission: when `cur_valid && !pause`:
  - Register the byte `cur_word[31-8*beat -: 8]` on `data_out`.
  - Set `valid_out` = 1, `lane_out` = `cur_lane`, `first_out` = (`beat` == 0).
  - Increment `beat`, which wraps 3→0.
  - On `beat` = 3, clear `cur_valid` unless it is reloaded in the same cycle.
- No emission (paused, or `cur_valid` = 0):
  - `valid_out` = 0 and `first_out` = 0.
  - `beat`, `cur`, `lane_out` hold.
  - `data_out` per Configuration.
- Reset values:
  - Internal: all state 0, `last_grant` = 1, so lane 0 wins first.
  - Outputs: `valid_out`, `lane_out`, `first_out` = 0.
  - `data_out` = 0, or `IDLE_BYTE` with the macro.
  - Pops are low during reset.
- Reset mid-word: the partial word and the prefetched word are discarded. Data returned by a pop issued in the reset cycle is ignored.

## Timing
- Fill latency: pop at edge-cycle T → data captured into `cur` at the end of T+1 → byte 0 on `data_out`/`valid_out` after the edge ending T+2.
- Steady state with either lane continuously non-empty: `valid_out` stays high with no bubbles. The four bytes of each word are contiguous, and `first_out` pulses every 4th byte.
- `pause` asserted in cycle T → `valid_out` = 0 after the edge ending T.
  - Resuming continues from the held `beat`.
  - No byte is dropped or duplicated.
- Buffering: at most 2 words buffered plus 1 in flight. With `pause` held, pops stop once `nxt_valid` = 1.

## Configuration
- `SCHED_IDLE_COMMA_EN`:
  - Defined: whenever `valid_out` = 0 (including reset), `data_out` = `IDLE_BYTE`.
  - Undefined: `data_out` holds its last value (0 after reset), and `IDLE_BYTE` is unused.

## Test plan
- Reset, both FIFOs empty: pops stay 0 and `valid_out` stays 0. `data_out` = 8'h00, or 8'hBC with the macro.
- Lane 0 supplies one word 32'hA1B2C3D4: `fifo0_pop` for 1 cycle; 3 cycles later the bytes A1, B2, C3, D4 appear on consecutive cycles, with `lane_out` = 0 and `first_out` only on A1.
- Both lanes always non-empty (lane 0 = 32'h11223344, lane 1 = 32'h55667788): pops alternate 0,1,0,1; the output stream is 11 22 33 44 55 66 77 88 with `valid_out` continuously high.
- `pause` high for 3 cycles right after byte B2: `valid_out` low for exactly 3 cycles, then C3, D4 follow. With both `cur` and `nxt` full during the pause, no further pop occurs.
- Only lane 1 non-empty after lane 0 was last granted, then lane 0 refilled: lane 1 is popped repeatedly; once both are non-empty, lane 0 gets the next grant.
- `reset` asserted after byte 1 of a word, with a prefetched word present: all outputs return to reset values the next cycle. After release, the first byte out comes from a freshly popped word with `first_out` = 1.

Source files
------------

// File: rtl/sched_conv_32_8.sv
// sched_conv_32_8: two-lane round-robin scheduler sharing one 32-to-8 serializer (MSB byte first).
// Optional macro SCHED_IDLE_COMMA_EN: data_out carries IDLE_BYTE whenever valid_out is low.
module sched_conv_32_8 #(
  parameter logic [7:0] IDLE_BYTE = 8'hBC
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic        fifo0_empty,
  input  logic [31:0] fifo0_data,
  output logic        fifo0_pop,
  input  logic        fifo1_empty,
  input  logic [31:0] fifo1_data,
  output logic        fifo1_pop,
  input  logic        pause,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        lane_out,
  output logic        first_out
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 32;

  typedef struct packed {
    logic             lane;
    logic [VEC_W-1:0] word;
  } slot_t;

`ifdef SCHED_IDLE_COMMA_EN
  localparam logic [7:0] DOUT_RST = IDLE_BYTE;
`else
  localparam logic [7:0] DOUT_RST = 8'h00;
  logic unused_idle;
  assign unused_idle = ^IDLE_BYTE;
`endif

  logic [NUM_LANES-1:0]            ne, pop;
  logic [NUM_LANES-1:0][VEC_W-1:0] rdata;

  slot_t      cur_q, cur_d, nxt_q, nxt_d, ret;
  logic       cur_valid_q, cur_valid_d, nxt_valid_q, nxt_valid_d;
  logic [1:0] beat_q, beat_d;
  logic       pend_q, pend_d, pend_lane_q, pend_lane_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] dout_q, dout_d;
  logic       valid_q, valid_d, lane_q, lane_d, first_q, first_d;

  logic             grant, pop_en, emit, cur_free;
  logic [3:0][7:0]  cur_bytes;

  assign ne    = {~fifo1_empty, ~fifo0_empty};
  assign rdata = {fifo1_data, fifo0_data};

  // Round-robin only matters when both lanes have data; otherwise take whichever does.
  assign grant  = (ne == 2'b11) ? ~last_grant_q : ne[1];
  assign pop_en = !reset && !pend_q && !nxt_valid_q && (|ne);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_pop
    assign pop[l] = pop_en && (grant == 1'(l));
  end

  assign fifo0_pop = pop[0];
  assign fifo1_pop = pop[1];

  assign ret       = {pend_lane_q, rdata[pend_lane_q]};
  assign emit      = cur_valid_q && !pause;
  assign cur_free  = !cur_valid_q || (emit && (beat_q == 2'd3));
  assign cur_bytes = cur_q.word;

  always_comb begin
    cur_d        = cur_q;
    cur_valid_d  = cur_valid_q;
    beat_d       = beat_q;
    nxt_d        = nxt_q;
    nxt_valid_d  = nxt_valid_q;
    pend_d       = pop_en;
    pend_lane_d  = pop_en ? grant : pend_lane_q;
    last_grant_d = pop_en ? grant : last_grant_q;
    dout_d       = dout_q;
    valid_d      = 1'b0;
    lane_d       = lane_q;
    first_d      = 1'b0;

    if (emit) begin
      dout_d  = cur_bytes[~beat_q];
      valid_d = 1'b1;
      lane_d  = cur_q.lane;
      first_d = (beat_q == 2'd0);
      beat_d  = beat_q + 2'd1;
    end
`ifdef SCHED_IDLE_COMMA_EN
    else begin
      dout_d = IDLE_BYTE;
    end
`endif

    // Prefetched word has priority over the returning pop data for the cur slot.
    if (cur_free) begin
      if (nxt_valid_q) begin
        cur_d       = nxt_q;
        cur_valid_d = 1'b1;
        beat_d      = 2'd0;
        nxt_valid_d = 1'b0;
        if (pend_q) begin
          nxt_d       = ret;
          nxt_valid_d = 1'b1;
        end
      end else if (pend_q) begin
        cur_d       = ret;
        cur_valid_d = 1'b1;
        beat_d      = 2'd0;
      end else begin
        cur_valid_d = 1'b0;
      end
    end else if (pend_q) begin
      nxt_d       = ret;
      nxt_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      cur_q        <= '0;
      cur_valid_q  <= 1'b0;
      beat_q       <= 2'd0;
      nxt_q        <= '0;
      nxt_valid_q  <= 1'b0;
      pend_q       <= 1'b0;
      pend_lane_q  <= 1'b0;
      last_grant_q <= 1'b1;
      dout_q       <= DOUT_RST;
      valid_q      <= 1'b0;
      lane_q       <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      cur_q        <= cur_d;
      cur_valid_q  <= cur_valid_d;
      beat_q       <= beat_d;
      nxt_q        <= nxt_d;
      nxt_valid_q  <= nxt_valid_d;
      pend_q       <= pend_d;
      pend_lane_q  <= pend_lane_d;
      last_grant_q <= last_grant_d;
      dout_q       <= dout_d;
      valid_q      <= valid_d;
      lane_q       <= lane_d;
      first_q      <= first_d;
    end
  end

  assign data_out  = dout_q;
  assign valid_out = valid_q;
  assign lane_out  = lane_q;
  assign first_out = first_q;

endmodule
